// File: rtl/exa_crosb_input_vc_buffer.sv
// Per-port input VC buffer feeding the crossbar arbiter: per-VC flit rings plus packet descriptor FIFOs.
// Build option: define CUT_THROUGH_EN to advertise packets on the head flit instead of waiting for the tail.
module exa_crosb_input_vc_buffer #(
  parameter int prio_num   = 2,
  parameter int vc_num     = 2,
  parameter int output_num = 4,
  parameter int data_width = 64,
  parameter int depth      = 16,
  localparam int NVC = prio_num * vc_num,
  localparam int VCW = (NVC > 1) ? $clog2(NVC) : 1,
  localparam int DW  = (output_num > 1) ? $clog2(output_num) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_valid,
  input  logic [VCW-1:0]            i_vc,
  input  logic [data_width-1:0]     i_data,
  input  logic                      i_last,
  input  logic [DW-1:0]             i_dest,
  input  logic [VCW-1:0]            i_output_vc,
  output logic [NVC-1:0]            o_has_packet,
  output logic [NVC-1:0][DW-1:0]    o_dest,
  output logic [NVC-1:0][VCW-1:0]   o_output_vc,
  input  logic [VCW-1:0]            i_sel_vc,
  input  logic                      i_cts,
  output logic [data_width-1:0]     o_data,
  output logic                      o_last,
  output logic                      o_credit_valid,
  output logic [VCW-1:0]            o_credit_vc,
  output logic                      o_overflow,
  output logic                      o_underflow
);
  localparam int PW = $clog2(depth);
  localparam int AW = $clog2(NVC * depth);
  localparam logic [PW:0] FULL = depth[PW:0];

  // Static partition: VC v owns entries [v*depth, v*depth+depth-1] of each shared array.
  function automatic logic [AW-1:0] addr(input logic [VCW-1:0] vc, input logic [PW-1:0] ptr);
    return AW'(vc) * AW'(depth) + AW'(ptr);
  endfunction

  logic [data_width:0]  mem_q      [NVC*depth];
  logic [DW-1:0]        dsc_dest_q [NVC*depth];
  logic [VCW-1:0]       dsc_ovc_q  [NVC*depth];
  logic                 dsc_cmp_q  [NVC*depth];

  logic [PW-1:0] wr_ptr_q [NVC];
  logic [PW-1:0] rd_ptr_q [NVC];
  logic [PW-1:0] dwr_ptr_q[NVC];
  logic [PW-1:0] drd_ptr_q[NVC];
  logic [PW:0]   cnt_q    [NVC];
  logic [PW:0]   dcnt_q   [NVC];
  logic [NVC-1:0] in_pkt_q;

  logic           credit_valid_q, credit_valid_d;
  logic [VCW-1:0] credit_vc_q, credit_vc_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;

  logic           wr_ok, head_wr, rd_avail, deq, stall;
  logic [AW-1:0]  rd_addr, wr_addr, dwr_addr, dnew_addr;
  logic [NVC-1:0] wr_v, rd_v, push_v, pop_v;

  always_comb begin
    wr_ok     = i_valid && (cnt_q[i_vc] != FULL);
    head_wr   = !in_pkt_q[i_vc];
    wr_addr   = addr(i_vc, wr_ptr_q[i_vc]);
    dwr_addr  = addr(i_vc, dwr_ptr_q[i_vc]);
    dnew_addr = addr(i_vc, dwr_ptr_q[i_vc] - 1'b1);
    rd_addr   = addr(i_sel_vc, rd_ptr_q[i_sel_vc]);
    o_data    = mem_q[rd_addr][data_width-1:0];
    o_last    = mem_q[rd_addr][data_width];
    rd_avail  = cnt_q[i_sel_vc] != '0;
    deq       = i_cts && rd_avail;
`ifdef CUT_THROUGH_EN
    // Ring drained but head packet still arriving: wait for more flits rather than flag an error.
    stall     = dcnt_q[i_sel_vc] != '0;
`else
    stall     = 1'b0;
`endif
    wr_v   = '0;
    rd_v   = '0;
    push_v = '0;
    pop_v  = '0;
    for (int v = 0; v < NVC; v++) begin
      wr_v[v]   = wr_ok && (i_vc == VCW'(v));
      rd_v[v]   = deq && (i_sel_vc == VCW'(v));
      push_v[v] = wr_v[v] && head_wr;
      pop_v[v]  = rd_v[v] && o_last;
    end
    credit_valid_d = deq;
    credit_vc_d    = deq ? i_sel_vc : credit_vc_q;
    ovf_d          = ovf_q | (i_valid & ~wr_ok);
    unf_d          = unf_q | (i_cts & ~rd_avail & ~stall);
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_addr] <= {i_last, i_data};
      if (head_wr) begin
        dsc_dest_q[dwr_addr] <= i_dest;
        dsc_ovc_q[dwr_addr]  <= i_output_vc;
        dsc_cmp_q[dwr_addr]  <= i_last;
      end else if (i_last) begin
        dsc_cmp_q[dnew_addr] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < NVC; v++) begin
        wr_ptr_q[v]  <= '0;
        rd_ptr_q[v]  <= '0;
        dwr_ptr_q[v] <= '0;
        drd_ptr_q[v] <= '0;
        cnt_q[v]     <= '0;
        dcnt_q[v]    <= '0;
      end
      in_pkt_q       <= '0;
      credit_valid_q <= 1'b0;
      credit_vc_q    <= '0;
      ovf_q          <= 1'b0;
      unf_q          <= 1'b0;
    end else begin
      for (int v = 0; v < NVC; v++) begin
        if (wr_v[v])   wr_ptr_q[v]  <= wr_ptr_q[v] + 1'b1;
        if (rd_v[v])   rd_ptr_q[v]  <= rd_ptr_q[v] + 1'b1;
        if (push_v[v]) dwr_ptr_q[v] <= dwr_ptr_q[v] + 1'b1;
        if (pop_v[v])  drd_ptr_q[v] <= drd_ptr_q[v] + 1'b1;
        if (wr_v[v] && !rd_v[v])      cnt_q[v] <= cnt_q[v] + 1'b1;
        else if (!wr_v[v] && rd_v[v]) cnt_q[v] <= cnt_q[v] - 1'b1;
        if (push_v[v] && !pop_v[v])      dcnt_q[v] <= dcnt_q[v] + 1'b1;
        else if (!push_v[v] && pop_v[v]) dcnt_q[v] <= dcnt_q[v] - 1'b1;
        if (wr_v[v]) in_pkt_q[v] <= !i_last;
      end
      credit_valid_q <= credit_valid_d;
      credit_vc_q    <= credit_vc_d;
      ovf_q          <= ovf_d;
      unf_q          <= unf_d;
    end
  end

  // Arbiter view is decoded from the head descriptor of each VC.
  always_comb begin
    o_has_packet = '0;
    o_dest       = '0;
    o_output_vc  = '0;
    for (int v = 0; v < NVC; v++) begin
      if (dcnt_q[v] != '0) begin
`ifdef CUT_THROUGH_EN
        o_has_packet[v] = 1'b1;
`else
        o_has_packet[v] = dsc_cmp_q[addr(VCW'(v), drd_ptr_q[v])];
`endif
        o_dest[v]      = dsc_dest_q[addr(VCW'(v), drd_ptr_q[v])];
        o_output_vc[v] = dsc_ovc_q[addr(VCW'(v), drd_ptr_q[v])];
      end
    end
  end

  assign o_credit_valid = credit_valid_q;
  assign o_credit_vc    = credit_vc_q;
  assign o_overflow     = ovf_q;
  assign o_underflow    = unf_q;

endmodule

// File: tb/tb_exa_crosb_input_vc_buffer.sv
// Directed bench for exa_crosb_input_vc_buffer: vector table plus hand-written corner sequences.
module tb_exa_crosb_input_vc_buffer;
  logic             clk = 1'b0;
  logic             reset;
  logic             i_valid;
  logic [1:0]       i_vc;
  logic [63:0]      i_data;
  logic             i_last;
  logic [1:0]       i_dest;
  logic [1:0]       i_output_vc;
  logic [3:0]       o_has_packet;
  logic [3:0][1:0]  o_dest;
  logic [3:0][1:0]  o_output_vc;
  logic [1:0]       i_sel_vc;
  logic             i_cts;
  logic [63:0]      o_data;
  logic             o_last;
  logic             o_credit_valid;
  logic [1:0]       o_credit_vc;
  logic             o_overflow;
  logic             o_underflow;

  exa_crosb_input_vc_buffer dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_vc(i_vc), .i_data(i_data),
    .i_last(i_last), .i_dest(i_dest), .i_output_vc(i_output_vc),
    .o_has_packet(o_has_packet), .o_dest(o_dest), .o_output_vc(o_output_vc),
    .i_sel_vc(i_sel_vc), .i_cts(i_cts), .o_data(o_data), .o_last(o_last),
    .o_credit_valid(o_credit_valid), .o_credit_vc(o_credit_vc),
    .o_overflow(o_overflow), .o_underflow(o_underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic v; logic [1:0] vc; logic [63:0] d; logic last; logic [1:0] dest; logic [1:0] ovc;
    logic [1:0] sel; logic cts;
    logic chk_d; logic [63:0] exp_d; logic exp_last;
    logic [3:0] exp_has; logic [7:0] exp_dest; logic [7:0] exp_ovc;
    logic exp_cv; logic [1:0] exp_cvc; logic exp_unf;
  } vec_t;

  vec_t tab[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] vc, input logic [63:0] d, input logic l,
                       input logic [1:0] dst, input logic [1:0] ov, input logic [1:0] sel,
                       input logic cts);
    i_valid = v; i_vc = vc; i_data = d; i_last = l; i_dest = dst; i_output_vc = ov;
    i_sel_vc = sel; i_cts = cts;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 64'h0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int ncred;
    //                 v     vc    data       last  dst   ovc   sel   cts   chk   exp_d      last  has      dest   ovc    cv    cvc   unf
    tab[0] = '{1'b1, 2'd2, 64'hA0, 1'b0, 2'd3, 2'd1, 2'd0, 1'b0, 1'b0, 64'h0,  1'b0, 4'b0000, 8'h30, 8'h10, 1'b0, 2'd0, 1'b0};
    tab[1] = '{1'b1, 2'd2, 64'hA1, 1'b0, 2'd3, 2'd1, 2'd0, 1'b0, 1'b0, 64'h0,  1'b0, 4'b0000, 8'h30, 8'h10, 1'b0, 2'd0, 1'b0};
    tab[2] = '{1'b1, 2'd2, 64'hA2, 1'b1, 2'd3, 2'd1, 2'd0, 1'b0, 1'b0, 64'h0,  1'b0, 4'b0100, 8'h30, 8'h10, 1'b0, 2'd0, 1'b0};
    tab[3] = '{1'b0, 2'd0, 64'h0,  1'b0, 2'd0, 2'd0, 2'd2, 1'b1, 1'b1, 64'hA0, 1'b0, 4'b0100, 8'h30, 8'h10, 1'b1, 2'd2, 1'b0};
    tab[4] = '{1'b0, 2'd0, 64'h0,  1'b0, 2'd0, 2'd0, 2'd2, 1'b1, 1'b1, 64'hA1, 1'b0, 4'b0100, 8'h30, 8'h10, 1'b1, 2'd2, 1'b0};
    tab[5] = '{1'b0, 2'd0, 64'h0,  1'b0, 2'd0, 2'd0, 2'd2, 1'b1, 1'b1, 64'hA2, 1'b1, 4'b0000, 8'h00, 8'h00, 1'b1, 2'd2, 1'b0};
    tab[6] = '{1'b0, 2'd0, 64'h0,  1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 64'h0,  1'b0, 4'b0000, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0};
    tab[7] = '{1'b0, 2'd0, 64'h0,  1'b0, 2'd0, 2'd0, 2'd3, 1'b1, 1'b0, 64'h0,  1'b0, 4'b0000, 8'h00, 8'h00, 1'b0, 2'd0, 1'b1};
    tab[8] = '{1'b0, 2'd0, 64'h0,  1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 64'h0,  1'b0, 4'b0000, 8'h00, 8'h00, 1'b0, 2'd0, 1'b1};
`ifdef CUT_THROUGH_EN
    tab[0].exp_has = 4'b0100;
    tab[1].exp_has = 4'b0100;
`endif

    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_has", 64'(o_has_packet), 64'h0);
    chk("rst_dest", 64'(o_dest), 64'h0);
    chk("rst_ovc", 64'(o_output_vc), 64'h0);
    chk("rst_cv", 64'(o_credit_valid), 64'h0);
    chk("rst_cvc", 64'(o_credit_vc), 64'h0);
    chk("rst_ovf", 64'(o_overflow), 64'h0);
    chk("rst_unf", 64'(o_underflow), 64'h0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      drive(tab[i].v, tab[i].vc, tab[i].d, tab[i].last, tab[i].dest, tab[i].ovc, tab[i].sel, tab[i].cts);
      @(negedge clk);
      if (tab[i].chk_d) begin
        chk($sformatf("v%0d_data", i), o_data, tab[i].exp_d);
        chk($sformatf("v%0d_last", i), 64'(o_last), 64'(tab[i].exp_last));
      end
      tick();
      chk($sformatf("v%0d_has", i), 64'(o_has_packet), 64'(tab[i].exp_has));
      chk($sformatf("v%0d_dest", i), 64'(o_dest), 64'(tab[i].exp_dest));
      chk($sformatf("v%0d_ovc", i), 64'(o_output_vc), 64'(tab[i].exp_ovc));
      chk($sformatf("v%0d_cv", i), 64'(o_credit_valid), 64'(tab[i].exp_cv));
      if (tab[i].exp_cv) chk($sformatf("v%0d_cvc", i), 64'(o_credit_vc), 64'(tab[i].exp_cvc));
      chk($sformatf("v%0d_unf", i), 64'(o_underflow), 64'(tab[i].exp_unf));
      chk($sformatf("v%0d_ovf", i), 64'(o_overflow), 64'h0);
    end

    // Fill VC0 with 16 single-flit packets, overflow on the 17th, drain through the wrap.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 2'd0, 64'h100 + 64'(i), 1'b1, 2'((i + 1) % 4), 2'(i % 4), 2'd0, 1'b0);
      tick();
    end
    chk("fill_has", 64'(o_has_packet), 64'h1);
    chk("fill_dest", 64'(o_dest), 64'h01);
    chk("fill_ovf", 64'(o_overflow), 64'h0);
    drive(1'b1, 2'd0, 64'hDEAD, 1'b1, 2'd3, 2'd3, 2'd0, 1'b0);
    tick();
    chk("ovf_set", 64'(o_overflow), 64'h1);
    ncred = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 2'd0, 64'h0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1);
      @(negedge clk);
      chk($sformatf("drain%0d_data", i), o_data, 64'h100 + 64'(i));
      chk($sformatf("drain%0d_last", i), 64'(o_last), 64'h1);
      chk($sformatf("drain%0d_dest", i), 64'(o_dest[0]), 64'((i + 1) % 4));
      tick();
      if (o_credit_valid && o_credit_vc == 2'd0) ncred++;
    end
    chk("drain_credits", 64'(ncred), 64'd16);
    chk("drain_has", 64'(o_has_packet), 64'h0);
    drive(1'b0, 2'd0, 64'h0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1);
    tick();
    chk("dropped_not_stored", 64'(o_credit_valid), 64'h0);
    drive(1'b1, 2'd0, 64'h1F0, 1'b1, 2'd2, 2'd1, 2'd0, 1'b0);
    tick();
    drive(1'b0, 2'd0, 64'h0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1);
    @(negedge clk);
    chk("wrap_data", o_data, 64'h1F0);
    tick();
    chk("wrap_cv", 64'(o_credit_valid), 64'h1);

    // Simultaneous write and dequeue on VC1 at count 5.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'd1, 64'h200 + 64'(i), 1'b0, 2'd2, 2'd3, 2'd0, 1'b0);
      tick();
    end
    drive(1'b1, 2'd1, 64'h205, 1'b1, 2'd2, 2'd3, 2'd1, 1'b1);
    @(negedge clk);
    chk("rw_head", o_data, 64'h200);
    tick();
    chk("rw_has", 64'(o_has_packet), 64'h2);
    chk("rw_cvc", 64'(o_credit_vc), 64'h1);
    for (int i = 1; i < 6; i++) begin
      drive(1'b0, 2'd0, 64'h0, 1'b0, 2'd0, 2'd0, 2'd1, 1'b1);
      @(negedge clk);
      chk($sformatf("rw%0d_data", i), o_data, 64'h200 + 64'(i));
      chk($sformatf("rw%0d_last", i), 64'(o_last), 64'(i == 5));
      tick();
      chk($sformatf("rw%0d_cv", i), 64'(o_credit_valid), 64'h1);
    end
    chk("rw_has_done", 64'(o_has_packet), 64'h0);
    drive(1'b0, 2'd0, 64'h0, 1'b0, 2'd0, 2'd0, 2'd1, 1'b1);
    tick();
    chk("rw_count5", 64'(o_credit_valid), 64'h0);

    // Reset in the middle of a packet on VC1.
    drive(1'b1, 2'd1, 64'h2AA, 1'b0, 2'd2, 2'd3, 2'd0, 1'b0);
    tick();
    chk("mid_dest", 64'(o_dest), 64'h08);
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_has", 64'(o_has_packet), 64'h0);
    chk("mrst_dest", 64'(o_dest), 64'h0);
    chk("mrst_ovc", 64'(o_output_vc), 64'h0);
    chk("mrst_cv", 64'(o_credit_valid), 64'h0);
    chk("mrst_cvc", 64'(o_credit_vc), 64'h0);
    chk("mrst_ovf", 64'(o_overflow), 64'h0);
    chk("mrst_unf", 64'(o_underflow), 64'h0);

`ifdef CUT_THROUGH_EN
    drive(1'b1, 2'd3, 64'h400, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
    tick();
    chk("ct_has_head", 64'(o_has_packet), 64'h8);
    drive(1'b0, 2'd0, 64'h0, 1'b0, 2'd0, 2'd0, 2'd3, 1'b1);
    @(negedge clk);
    chk("ct_data0", o_data, 64'h400);
    tick();
    chk("ct_cv0", 64'(o_credit_valid), 64'h1);
    tick();
    chk("ct_stall_cv", 64'(o_credit_valid), 64'h0);
    chk("ct_stall_unf", 64'(o_underflow), 64'h0);
    chk("ct_stall_has", 64'(o_has_packet), 64'h8);
    drive(1'b1, 2'd3, 64'h401, 1'b1, 2'd0, 2'd0, 2'd0, 1'b0);
    tick();
    drive(1'b0, 2'd0, 64'h0, 1'b0, 2'd0, 2'd0, 2'd3, 1'b1);
    @(negedge clk);
    chk("ct_data1", o_data, 64'h401);
    chk("ct_last1", 64'(o_last), 64'h1);
    tick();
    chk("ct_has_done", 64'(o_has_packet), 64'h0);
`endif

    drive(1'b1, 2'd1, 64'h300, 1'b1, 2'd1, 2'd2, 2'd0, 1'b0);
    tick();
    chk("new_has", 64'(o_has_packet), 64'h2);
    chk("new_dest", 64'(o_dest), 64'h04);
    chk("new_ovc", 64'(o_output_vc), 64'h08);
    drive(1'b0, 2'd0, 64'h0, 1'b0, 2'd0, 2'd0, 2'd1, 1'b1);
    @(negedge clk);
    chk("new_data", o_data, 64'h300);
    chk("new_last", 64'(o_last), 64'h1);
    tick();
    chk("new_cv", 64'(o_credit_valid), 64'h1);
    chk("new_cvc", 64'(o_credit_vc), 64'h1);
    chk("new_has_done", 64'(o_has_packet), 64'h0);
    chk("new_unf", 64'(o_underflow), 64'h0);
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
